// File: rtl/acct_min_cost_window.sv
// acct_min_cost_window: sliding-window minimum-cost account selector.
// Takes (account, A, T) records. Once WIN records have been accepted, it emits
// one result per accepted record: the account with the smallest A*T in the
// current window. On equal cost the newest record wins.
// Optional feature macro: ACCT_WIN_COST_OUT_EN adds the out_cost port, which
// carries the winning cost.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready             record handshake
//   in_account, in_A, in_T        record payload
//   out_valid/out_ready           result handshake
//   out_account                   selected account ID
//   out_cost (optional)           winning cost, 2*DSIZE bits
module acct_min_cost_window #(
   parameter int unsigned DSIZE = 8,
   parameter int unsigned WIN   = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DSIZE-1:0]   in_account,
   input  logic [DSIZE-1:0]   in_A,
   input  logic [DSIZE-1:0]   in_T,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DSIZE-1:0]   out_account
`ifdef ACCT_WIN_COST_OUT_EN
   ,
   output logic [2*DSIZE-1:0] out_cost
`endif
);

   localparam int unsigned CW = 2 * DSIZE;
   localparam int unsigned FW = $clog2(WIN + 1);

   typedef enum logic {FILL, RUN} state_t;

   state_t           state;
   logic [FW-1:0]    fill;
   logic [DSIZE-1:0] win_acct [WIN];
   logic [CW-1:0]    win_cost [WIN];
   logic [DSIZE-1:0] nxt_acct [WIN];
   logic [CW-1:0]    nxt_cost [WIN];
   logic [DSIZE-1:0] best_acct;
   logic [CW-1:0]    best_cost;
   logic             accept;

   // in_ready depends only on registered state, out_ready and rst.
   // It never depends on in_valid.
   assign in_ready = !rst && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   // Post-shift window: the incoming record goes to slot 0.
   always_comb begin
      nxt_acct[0] = in_account;
      nxt_cost[0] = CW'(in_A) * CW'(in_T);
      for (int unsigned i = 1; i < WIN; i++) begin
         nxt_acct[i] = win_acct[i-1];
         nxt_cost[i] = win_cost[i-1];
      end
   end

   // Minimum search from the oldest slot to the newest.
   // The '<=' test lets a newer slot take over on a tie.
   always_comb begin
      best_acct = nxt_acct[WIN-1];
      best_cost = nxt_cost[WIN-1];
      for (int i = int'(WIN) - 2; i >= 0; i--) begin
         if (nxt_cost[i] <= best_cost) begin
            best_acct = nxt_acct[i];
            best_cost = nxt_cost[i];
         end
      end
   end

   // Window shift register, fill counter, FSM and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= FILL;
         fill        <= '0;
         out_valid   <= 1'b0;
         out_account <= '0;
`ifdef ACCT_WIN_COST_OUT_EN
         out_cost    <= '0;
`endif
         for (int unsigned i = 0; i < WIN; i++) begin
            win_acct[i] <= '0;
            win_cost[i] <= '0;
         end
      end else begin
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (accept) begin
            for (int unsigned i = 0; i < WIN; i++) begin
               win_acct[i] <= nxt_acct[i];
               win_cost[i] <= nxt_cost[i];
            end
            case (state)
               FILL: begin
                  fill <= fill + FW'(1);
                  if (fill == FW'(WIN - 1)) begin
                     state       <= RUN;
                     out_valid   <= 1'b1;
                     out_account <= best_acct;
`ifdef ACCT_WIN_COST_OUT_EN
                     out_cost    <= best_cost;
`endif
                  end
               end
               RUN: begin
                  out_valid   <= 1'b1;
                  out_account <= best_acct;
`ifdef ACCT_WIN_COST_OUT_EN
                  out_cost    <= best_cost;
`endif
               end
               default: state <= FILL;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_acct_min_cost_window.sv
// Testbench for acct_min_cost_window.
// It keeps a scoreboard of expected results and runs the directed scenarios
// followed by a random streaming run.
module tb_acct_min_cost_window;

   localparam int unsigned DSIZE = 8;
   localparam int unsigned WIN   = 5;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [DSIZE-1:0] in_account = '0;
   logic [DSIZE-1:0] in_A = '0;
   logic [DSIZE-1:0] in_T = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [DSIZE-1:0] out_account;
`ifdef ACCT_WIN_COST_OUT_EN
   logic [2*DSIZE-1:0] out_cost;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int n_out    = 0;

   // Reference model: the newest record is kept at index 0.
   logic [DSIZE-1:0]   m_acct [$];
   logic [2*DSIZE-1:0] m_cost [$];
   logic [DSIZE-1:0]   exp_acct [$];
   logic [2*DSIZE-1:0] exp_cost [$];

   always #5 clk = ~clk;

   acct_min_cost_window #(.DSIZE(DSIZE), .WIN(WIN)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_account  (in_account),
      .in_A        (in_A),
      .in_T        (in_T),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_account (out_account)
`ifdef ACCT_WIN_COST_OUT_EN
      ,
      .out_cost    (out_cost)
`endif
   );

   // One clock: drive inputs on the falling edge, then score the handshakes
   // just before the rising edge, then return at the rising edge.
   task automatic cycle(input logic r, input logic v, input logic [DSIZE-1:0] acc,
                        input logic [DSIZE-1:0] a, input logic [DSIZE-1:0] t,
                        input logic ordy, output logic accepted);
      logic [DSIZE-1:0]   e;
      logic [2*DSIZE-1:0] ec;
      int                 best;
      @(negedge clk);
      rst = r; in_valid = v; in_account = acc; in_A = a; in_T = t; out_ready = ordy;
      #1;
      accepted = 1'b0;
      if (r) begin
         m_acct.delete(); m_cost.delete(); exp_acct.delete(); exp_cost.delete();
      end else begin
         if (out_valid && out_ready) begin
            n_checks++;
            if (exp_acct.size() == 0) begin
               n_fail++;
               $display("FAIL sb_unexpected: out_account=%0d but no result expected", out_account);
            end else begin
               e  = exp_acct.pop_front();
               ec = exp_cost.pop_front();
               n_out++;
               if (out_account !== e) begin
                  n_fail++;
                  $display("FAIL sb_account: got %0d expected %0d", out_account, e);
               end
`ifdef ACCT_WIN_COST_OUT_EN
               n_checks++;
               if (out_cost !== ec) begin
                  n_fail++;
                  $display("FAIL sb_cost: got %0d expected %0d", out_cost, ec);
               end
`endif
            end
         end
         if (v && in_ready) begin
            accepted = 1'b1;
            m_acct.push_front(acc);
            m_cost.push_front((2*DSIZE)'(a) * (2*DSIZE)'(t));
            if (m_acct.size() > WIN) begin
               void'(m_acct.pop_back());
               void'(m_cost.pop_back());
            end
            if (m_acct.size() == WIN) begin
               best = 0;
               for (int i = 1; i < int'(WIN); i++)
                  if (m_cost[i] < m_cost[best]) best = i;
               exp_acct.push_back(m_acct[best]);
               exp_cost.push_back(m_cost[best]);
            end
         end
      end
      @(posedge clk);
   endtask

   task automatic test_reset();
      logic acc;
      for (int k = 0; k < 2; k++) begin
         cycle(1'b1, 1'b1, 8'd7, 8'd1, 8'd1, 1'b1, acc);
         #1;
         n_checks++;
         if (out_valid !== 1'b0 || out_account !== '0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: out_valid=%b out_account=%0d in_ready=%b expected 0/0/0",
                     out_valid, out_account, in_ready);
         end
      end
      cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, acc);
   endtask

   task automatic test_fill_slide();
      logic acc;
      int   out0;
      logic [DSIZE-1:0] ac [5] = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14};
      logic [DSIZE-1:0] aa [5] = '{8'd2, 8'd1, 8'd5, 8'd4, 8'd3};
      logic [DSIZE-1:0] tt [5] = '{8'd3, 8'd5, 8'd1, 8'd4, 8'd3};
      out0 = n_out;
      for (int k = 0; k < 5; k++) begin
         cycle(1'b0, 1'b1, ac[k], aa[k], tt[k], 1'b1, acc);
         #1;
         n_checks++;
         if (k < 4 && out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_no_output: out_valid=%b after %0d records, expected 0", out_valid, k + 1);
         end
      end
      n_checks++;
      if (out_valid !== 1'b1 || out_account !== 8'd12) begin
         n_fail++;
         $display("FAIL fill_tie: out_valid=%b out_account=%0d expected 1/12", out_valid, out_account);
      end
      cycle(1'b0, 1'b1, 8'd15, 8'd0, 8'd200, 1'b1, acc);
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_account !== 8'd15) begin
         n_fail++;
         $display("FAIL slide_zero: out_valid=%b out_account=%0d expected 1/15", out_valid, out_account);
      end
      cycle(1'b0, 1'b1, 8'd16, 8'd255, 8'd255, 1'b1, acc);
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_account !== 8'd15) begin
         n_fail++;
         $display("FAIL slide_big: out_valid=%b out_account=%0d expected 1/15", out_valid, out_account);
      end
      cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, acc);
      #1;
      n_checks++;
      if (n_out - out0 != 3 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL slide_count: outputs=%0d out_valid=%b expected 3/0", n_out - out0, out_valid);
      end
   endtask

   task automatic test_max_ties();
      logic acc;
      cycle(1'b1, 1'b0, '0, '0, '0, 1'b1, acc);
      for (int k = 1; k <= 5; k++)
         cycle(1'b0, 1'b1, DSIZE'(k), 8'd255, 8'd255, 1'b1, acc);
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_account !== 8'd5) begin
         n_fail++;
         $display("FAIL max_tie: out_valid=%b out_account=%0d expected 1/5", out_valid, out_account);
      end
`ifdef ACCT_WIN_COST_OUT_EN
      n_checks++;
      if (out_cost !== 16'd65025) begin
         n_fail++;
         $display("FAIL max_tie_cost: got %0d expected 65025", out_cost);
      end
`endif
      cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, acc);
   endtask

   task automatic test_backpressure();
      logic acc;
      logic [DSIZE-1:0] ac [5] = '{8'd30, 8'd31, 8'd32, 8'd33, 8'd34};
      logic [DSIZE-1:0] aa [5] = '{8'd3, 8'd2, 8'd9, 8'd1, 8'd7};
      logic [DSIZE-1:0] tt [5] = '{8'd3, 8'd2, 8'd1, 8'd1, 8'd7};
      cycle(1'b1, 1'b0, '0, '0, '0, 1'b0, acc);
      for (int k = 0; k < 5; k++)
         cycle(1'b0, 1'b1, ac[k], aa[k], tt[k], 1'b0, acc);
      for (int k = 0; k < 10; k++) begin
         cycle(1'b0, 1'b1, 8'd40, 8'd0, 8'd9, 1'b0, acc);
         #1;
         n_checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_account !== 8'd33 || acc !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold: in_ready=%b out_valid=%b out_account=%0d acc=%b expected 0/1/33/0",
                     in_ready, out_valid, out_account, acc);
         end
      end
      cycle(1'b0, 1'b1, 8'd40, 8'd0, 8'd9, 1'b1, acc);
      #1;
      n_checks++;
      if (acc !== 1'b1 || out_valid !== 1'b1 || out_account !== 8'd40) begin
         n_fail++;
         $display("FAIL bp_release: acc=%b out_valid=%b out_account=%0d expected 1/1/40",
                  acc, out_valid, out_account);
      end
      cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, acc);
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || exp_acct.size() != 0) begin
         n_fail++;
         $display("FAIL bp_drain: out_valid=%b pending=%0d expected 0/0", out_valid, exp_acct.size());
      end
   endtask

   task automatic test_mid_reset();
      logic acc;
      logic [DSIZE-1:0] ac [5] = '{8'd20, 8'd21, 8'd22, 8'd23, 8'd24};
      logic [DSIZE-1:0] aa [5] = '{8'd1, 8'd2, 8'd5, 8'd2, 8'd3};
      logic [DSIZE-1:0] tt [5] = '{8'd7, 8'd3, 8'd5, 8'd2, 8'd3};
      for (int k = 0; k < 3; k++)
         cycle(1'b0, 1'b1, 8'd99, 8'd0, 8'd0, 1'b1, acc);
      cycle(1'b1, 1'b0, '0, '0, '0, 1'b1, acc);
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || out_account !== '0) begin
         n_fail++;
         $display("FAIL mid_reset: out_valid=%b out_account=%0d expected 0/0", out_valid, out_account);
      end
      for (int k = 0; k < 5; k++) begin
         cycle(1'b0, 1'b1, ac[k], aa[k], tt[k], 1'b1, acc);
         #1;
         n_checks++;
         if ((k < 4 && out_valid !== 1'b0) ||
             (k == 4 && (out_valid !== 1'b1 || out_account !== 8'd23))) begin
            n_fail++;
            $display("FAIL mid_reset_refill: step=%0d out_valid=%b out_account=%0d", k, out_valid, out_account);
         end
      end
      cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, acc);
   endtask

   task automatic test_stream();
      logic acc;
      int   accepted;
      int   out0;
      logic v;
      logic ordy;
      logic [DSIZE-1:0] a;
      logic [DSIZE-1:0] t;
      cycle(1'b1, 1'b0, '0, '0, '0, 1'b1, acc);
      out0 = n_out;
      accepted = 0;
      for (int c = 0; c < 30000 && accepted < 4000; c++) begin
         v    = ($urandom_range(0, 4) != 0);
         ordy = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 1) == 1) begin
            a = DSIZE'($urandom_range(0, 7));
            t = DSIZE'($urandom_range(0, 7));
         end else begin
            a = DSIZE'($urandom_range(0, 255));
            t = DSIZE'($urandom_range(0, 255));
         end
         cycle(1'b0, v, DSIZE'($urandom_range(0, 255)), a, t, ordy, acc);
         if (acc) accepted++;
      end
      for (int c = 0; c < 20 && (exp_acct.size() != 0 || out_valid); c++)
         cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, acc);
      n_checks++;
      if (accepted != 4000 || n_out - out0 != 3996 || exp_acct.size() != 0) begin
         n_fail++;
         $display("FAIL stream_count: accepted=%0d results=%0d pending=%0d expected 4000/3996/0",
                  accepted, n_out - out0, exp_acct.size());
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_fill_slide();
      test_max_ties();
      test_backpressure();
      test_mid_reset();
      test_stream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
